// File: rtl/step_pulse_gen_if.sv
// Handshake/status bundle between the step-pulse source and its consumer.
// master drives the run controls, slave is the generator itself.
interface step_pulse_gen_if;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       pulse;
    logic       running;
    logic [9:0] sec_count;
    logic [7:0] cur_rate;
    logic       done;

    modport master (
        output start, stop, mode,
        input  pulse, running, sec_count, cur_rate, done
    );

    modport slave (
        input  start, stop, mode,
        output pulse, running, sec_count, cur_rate, done
    );
endinterface

// File: rtl/step_pulse_gen.sv
// Evenly spaced step-pulse source with per-second rate profiles.
// Optional run limit enabled by defining STEPGEN_LIMIT_EN.
module step_pulse_gen #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int PULSE_W     = 4,
    parameter int MAX_SECONDS = 300
) (
    input  logic             clk,
    input  logic             reset,
    step_pulse_gen_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [31:0] HZ      = 32'(CLK_HZ);
    localparam logic [31:0] LAST    = 32'(CLK_HZ - 1);
    localparam logic [7:0]  PW_M1   = 8'(PULSE_W - 1);
    localparam logic [9:0]  SEC_MAX = 10'(MAX_SECONDS);
`ifdef STEPGEN_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  mode_q;
    logic [31:0] cyc_q;
    logic [31:0] acc_q;
    logic [9:0]  sec_q;
    logic [7:0]  rate_q;
    logic        pulse_q;
    logic [7:0]  wcnt_q;

    logic [31:0] t;
    logic        fire;
    logic        wrap;
    logic [9:0]  sec_nxt;
    logic        lim_hit;
    logic        go;
    logic        leave;

    function automatic logic [7:0] rate_of(
        input logic [1:0] m,
        input logic [9:0] s
    );
        logic [7:0] r;
        r = 8'd0;
        case (m)
            2'd0: r = 8'd32;
            2'd1: r = 8'd64;
            2'd2: r = 8'd128;
            default: begin
                case (s)
                    10'd0:   r = 8'd20;
                    10'd1:   r = 8'd33;
                    10'd2:   r = 8'd66;
                    10'd3:   r = 8'd27;
                    10'd4:   r = 8'd70;
                    10'd5:   r = 8'd30;
                    10'd6:   r = 8'd19;
                    10'd7:   r = 8'd30;
                    10'd8:   r = 8'd33;
                    default: r = 8'd69;
                endcase
            end
        endcase
        return r;
    endfunction

    assign t       = acc_q + {24'd0, rate_q};
    assign fire    = (state_q == RUN) && (t >= HZ);
    assign wrap    = (state_q == RUN) && (cyc_q == LAST);
    assign sec_nxt = (sec_q == 10'h3FF) ? sec_q : sec_q + 10'd1;
    assign lim_hit = LIMIT_EN && wrap && (sec_nxt == SEC_MAX);

    // Next-state logic: stop beats start, limit ends the run on a boundary.
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        leave   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
                    go      = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop || lim_hit) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Second timing, rate selection and phase accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 2'd0;
            cyc_q  <= '0;
            acc_q  <= '0;
            sec_q  <= '0;
            rate_q <= '0;
        end else if (go) begin
            mode_q <= bus.mode;
            sec_q  <= '0;
            rate_q <= rate_of(bus.mode, 10'd0);
            acc_q  <= '0;
            cyc_q  <= '0;
        end else if (state_q == RUN) begin
            if (wrap) begin
                sec_q  <= sec_nxt;
                rate_q <= rate_of(mode_q, sec_nxt);
            end
            if (wrap || leave) begin
                acc_q <= '0;
                cyc_q <= '0;
            end else begin
                cyc_q <= cyc_q + 32'd1;
                acc_q <= fire ? t - HZ : t;
            end
        end
    end

    // Pulse stretcher: a fire while high is dropped, in-flight pulses finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q <= 1'b0;
            wcnt_q  <= '0;
        end else if (pulse_q) begin
            if (wcnt_q == 8'd0) begin
                pulse_q <= 1'b0;
            end else begin
                wcnt_q <= wcnt_q - 8'd1;
            end
        end else if (fire) begin
            pulse_q <= 1'b1;
            wcnt_q  <= PW_M1;
        end
    end

`ifdef STEPGEN_LIMIT_EN
    logic done_q;

    // One-cycle strobe when the run limit is reached without a stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= lim_hit && !bus.stop;
        end
    end

    assign bus.done = done_q;
`else
    assign bus.done = 1'b0;
`endif

    assign bus.pulse     = pulse_q;
    assign bus.running   = (state_q == RUN);
    assign bus.sec_count = sec_q;
    assign bus.cur_rate  = rate_q;
endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen at CLK_HZ=1000, PULSE_W=4.
// Counts pulses per one-second window against a queued rate model.
module tb_step_pulse_gen;
    localparam int HZ = 1000;
    localparam int PW = 4;
    localparam int LIM_S = 2;
`ifdef STEPGEN_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    step_pulse_gen_if sif ();

    step_pulse_gen #(
        .CLK_HZ(HZ),
        .PULSE_W(PW),
        .MAX_SECONDS(LIM_S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(sif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int nsec;
        int rate0;
    } vec_t;

    typedef struct {
        int cnt;
        int sec;
        int rate;
    } exp_t;

    exp_t sb[$];
    vec_t vt[4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rises = 0;
    int hi_len = 0;
    int bad_w = 0;
    int done_n = 0;
    int done_at = -1;
    logic prev_p = 1'b0;

    function automatic int mrate(input int m, input int s);
        int r;
        case (m)
            0: r = 32;
            1: r = 64;
            2: r = 128;
            default: begin
                case (s)
                    0: r = 20;
                    1: r = 33;
                    2: r = 66;
                    3: r = 27;
                    4: r = 70;
                    5: r = 30;
                    6: r = 19;
                    7: r = 30;
                    8: r = 33;
                    default: r = 69;
                endcase
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sif.pulse && !prev_p) rises++;
        if (sif.pulse) begin
            hi_len++;
        end else if (prev_p) begin
            if (hi_len != PW) bad_w++;
            hi_len = 0;
        end
        if (sif.done) begin
            done_n++;
            done_at = cyc;
        end
        prev_p = sif.pulse;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic begin_run(input int m, input int nsec, input int rate0);
        exp_t e;
        int ns;
        for (int n = 0; n < nsec; n++) begin
            e.cnt = (LIM && n >= LIM_S) ? 0 : mrate(m, n);
            ns = n + 1;
            if (LIM && ns > LIM_S) ns = LIM_S;
            e.sec = ns;
            e.rate = mrate(m, ns);
            sb.push_back(e);
        end
        sif.mode = 2'(m);
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        chk("run_start_running", int'(sif.running), 1);
        chk("run_start_rate", int'(sif.cur_rate), rate0);
        chk("run_start_sec", int'(sif.sec_count), 0);
    endtask

    task automatic windows(input int nsec, input int chg_k,
                           input logic [1:0] chg_m);
        int k;
        k = 0;
        for (int n = 0; n < nsec; n++) begin
            int r0;
            exp_t e;
            r0 = rises;
            for (int i = 0; i < HZ; i++) begin
                if (k == chg_k) sif.mode = chg_m;
                tick();
                k++;
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty actual=0 required=entry");
            end else begin
                e = sb.pop_front();
                chk($sformatf("cnt_s%0d", n), rises - r0, e.cnt);
                chk($sformatf("sec_s%0d", n), int'(sif.sec_count), e.sec);
                chk($sformatf("rate_s%0d", n), int'(sif.cur_rate), e.rate);
            end
        end
    endtask

    task automatic do_stop();
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;
        chk("stop_running", int'(sif.running), 0);
    endtask

    initial begin
        int r0;
        int s0;
        int d0;
        int w;

        vt[0] = '{mode: 0, nsec: 3,  rate0: 32};
        vt[1] = '{mode: 3, nsec: 11, rate0: 20};
        vt[2] = '{mode: 2, nsec: 2,  rate0: 128};
        vt[3] = '{mode: 1, nsec: 1,  rate0: 64};

        reset = 1'b1;
        sif.start = 1'b0;
        sif.stop = 1'b0;
        sif.mode = 2'd0;
        idle(3);
        chk("rst_pulse", int'(sif.pulse), 0);
        chk("rst_running", int'(sif.running), 0);
        chk("rst_done", int'(sif.done), 0);
        chk("rst_sec", int'(sif.sec_count), 0);
        chk("rst_rate", int'(sif.cur_rate), 0);
        reset = 1'b0;
        idle(3);

        for (int i = 0; i < 4; i++) begin
            begin_run(vt[i].mode, vt[i].nsec, vt[i].rate0);
            windows(vt[i].nsec, -1, 2'd0);
            do_stop();
            idle(10);
        end

        // stop mid-second: pulse in flight completes, then quiet
        r0 = rises;
        sif.mode = 2'd2;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        idle(500);
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;
        chk("stop500_running", int'(sif.running), 0);
        chk("stop500_inflight", int'(sif.pulse), 1);
        idle(20);
        chk("stop500_count", rises - r0, 64);
        chk("stop500_quiet", int'(sif.pulse), 0);

        // start and stop together stay idle
        r0 = rises;
        sif.start = 1'b1;
        sif.stop = 1'b1;
        tick();
        sif.start = 1'b0;
        sif.stop = 1'b0;
        chk("startstop_running", int'(sif.running), 0);
        idle(50);
        chk("startstop_quiet", rises - r0, 0);
        chk("startstop_idle", int'(sif.running), 0);

        // reset in the middle of a pulse
        sif.mode = 2'd1;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        idle(1700);
        w = 0;
        while (!sif.pulse && w < 40) begin
            tick();
            w++;
        end
        if (!sif.pulse) begin
            checks++;
            errors++;
            $display("FAIL pulse_wait actual=timeout required=pulse");
        end
        tick();
        prev_p = 1'b0;
        hi_len = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_pulse", int'(sif.pulse), 0);
        chk("midrst_running", int'(sif.running), 0);
        chk("midrst_done", int'(sif.done), 0);
        chk("midrst_sec", int'(sif.sec_count), 0);
        chk("midrst_rate", int'(sif.cur_rate), 0);
        idle(5);
        begin_run(1, 1, 64);
        windows(1, -1, 2'd0);
        do_stop();
        idle(10);

        // mode change during run is ignored until restart
        begin_run(1, 2, 64);
        windows(2, 300, 2'd2);
        do_stop();
        idle(10);
        begin_run(2, 1, 128);
        windows(1, -1, 2'd0);
        do_stop();
        idle(10);

`ifdef STEPGEN_LIMIT_EN
        // limited run ends on the boundary with a one-cycle done
        r0 = rises;
        d0 = done_n;
        sif.mode = 2'd0;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        s0 = cyc;
        idle(2100);
        chk("lim_count", rises - r0, 64);
        chk("lim_done_n", done_n - d0, 1);
        chk("lim_done_at", done_at - s0, 2000);
        chk("lim_running", int'(sif.running), 0);
`else
        s0 = cyc;
        d0 = 0;
        chk("no_done", done_n, d0);
        chk("cyc_advanced", int'(cyc > s0 - 1), 1);
`endif

        chk("pulse_width", bad_w, 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
